// File: rtl/riscv_if_biu.sv
// riscv_if_biu: bus interface unit for the instruction fetch stage.
//
// Issues in-order read requests for the PC presented by the fetch stage,
// tracks requests in flight, pairs in-order responses with their request
// address, and queues {data, pc, exception} entries for the fetch stage.
// A flush empties both queues and drops the responses still owed for
// requests issued before it. A misaligned PC generates a NOP entry flagged
// misaligned once the bus is quiet, without a bus request.
//
// Ports
//   clk, rstn              clock, async active-low reset
//   if_nxt_pc              PC requested by fetch
//   if_stall, if_flush     fetch back-pressure / discard pending fetches
//   if_stall_nxt_pc        fetch must hold if_nxt_pc
//   if_parcel*             parcel data, pc, per-half valid, exceptions
//   mem_req/mem_adr/mem_ack               request channel
//   mem_rvalid/mem_rdata/mem_err          in-order response channel
module riscv_if_biu #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32,
  parameter int DEPTH       = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [XLEN-1:0]           if_nxt_pc,
  input  logic                      if_stall,
  input  logic                      if_flush,
  output logic                      if_stall_nxt_pc,
  output logic [PARCEL_SIZE-1:0]    if_parcel,
  output logic [XLEN-1:0]           if_parcel_pc,
  output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
  output logic                      if_parcel_misaligned,
  output logic                      if_parcel_page_fault,
  output logic                      mem_req,
  output logic [XLEN-1:0]           mem_adr,
  input  logic                      mem_ack,
  input  logic                      mem_rvalid,
  input  logic [PARCEL_SIZE-1:0]    mem_rdata,
  input  logic                      mem_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam logic [PARCEL_SIZE-1:0] NOP = PARCEL_SIZE'(32'h0000_0013);

  typedef struct packed {
    logic [PARCEL_SIZE-1:0] data;
    logic [XLEN-1:0]        pc;
    logic                   misaligned;
    logic                   err;
  } rsp_t;

  logic [XLEN-1:0] adr_q [DEPTH];
  rsp_t            rsp_q [DEPTH];
  logic [AW-1:0]   adr_wp, adr_rp, rsp_wp, rsp_rp;
  logic [CW-1:0]   inflight, discard, queued;

  logic          aligned, room, accept, mis_push, rsp_ok, rsp_keep;
  logic          rsp_push, rsp_pop, rsp_empty;
  logic [SW-1:0] occ;
  rsp_t          rsp_in, head;

  // Occupancy counts both outstanding requests and parked responses so a
  // response always has a free slot when it arrives.
  assign occ      = {1'b0, inflight} + {1'b0, queued};
  assign room     = occ < SW'(DEPTH);
  assign aligned  = (if_nxt_pc[1:0] == 2'b00);

  assign mem_req  = rstn & ~if_flush & ~if_stall & room & aligned;
  assign mem_adr  = if_nxt_pc;
  assign accept   = mem_req & mem_ack;

  // Misaligned PC waits for the bus to drain so the NOP stays in order.
  assign mis_push = rstn & ~if_flush & ~if_stall & ~aligned &
                    (inflight == '0) & (queued < CW'(DEPTH));

  assign if_stall_nxt_pc = ~(accept | mis_push);

  // Responses with nothing outstanding are ignored.
  assign rsp_ok    = mem_rvalid & (inflight != '0);
  assign rsp_keep  = rsp_ok & (discard == '0);
  assign rsp_push  = (rsp_keep | mis_push) & ~if_flush;
  assign rsp_empty = (queued == '0);
  assign rsp_pop   = ~rsp_empty & ~if_stall & ~if_flush;

  always_comb begin
    rsp_in = '{data: mem_rdata, pc: adr_q[adr_rp], misaligned: 1'b0, err: mem_err};
    if (mis_push) rsp_in = '{data: NOP, pc: if_nxt_pc, misaligned: 1'b1, err: 1'b0};
  end

  assign head                 = rsp_empty ? '0 : rsp_q[rsp_rp];
  assign if_parcel            = head.data;
  assign if_parcel_pc         = head.pc;
  assign if_parcel_misaligned = head.misaligned;
  assign if_parcel_page_fault = head.err;
  assign if_parcel_valid      = {(PARCEL_SIZE/16){rsp_pop}};

  // Queue storage: contents are qualified by the pointers, no reset needed.
  always_ff @(posedge clk) begin
    if (accept)   adr_q[adr_wp] <= mem_adr;
    if (rsp_push) rsp_q[rsp_wp] <= rsp_in;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      adr_wp   <= '0;
      adr_rp   <= '0;
      rsp_wp   <= '0;
      rsp_rp   <= '0;
      inflight <= '0;
      discard  <= '0;
      queued   <= '0;
    end else if (if_flush) begin
      // Everything still owed by the bus is stale; a response landing this
      // cycle already settles one of them.
      adr_wp   <= '0;
      adr_rp   <= '0;
      rsp_wp   <= '0;
      rsp_rp   <= '0;
      queued   <= '0;
      inflight <= inflight - CW'(rsp_ok);
      discard  <= inflight - CW'(rsp_ok);
    end else begin
      if (accept)                     adr_wp  <= adr_wp + 1'b1;
      if (rsp_keep)                   adr_rp  <= adr_rp + 1'b1;
      if (rsp_ok && discard != '0)    discard <= discard - 1'b1;
      inflight <= inflight + CW'(accept) - CW'(rsp_ok);
      if (rsp_push)                   rsp_wp  <= rsp_wp + 1'b1;
      if (rsp_pop)                    rsp_rp  <= rsp_rp + 1'b1;
      queued   <= queued + CW'(rsp_push) - CW'(rsp_pop);
    end
  end

endmodule

// File: tb/tb_riscv_if_biu.sv
// tb_riscv_if_biu: self-checking bench for riscv_if_biu (DEPTH=2).
// Issue-condition vectors from a table, directed multi-cycle sequences, and
// a randomized in-order stream; parcels are checked against a scoreboard
// filled whenever a response (or misaligned NOP) is driven.
module tb_riscv_if_biu;
  localparam int XLEN = 32, PS = 32, DEPTH = 2;

  logic            clk = 1'b0, rstn = 1'b0;
  logic [XLEN-1:0] if_nxt_pc = '0;
  logic            if_stall = 1'b1, if_flush = 1'b0;
  logic            if_stall_nxt_pc;
  logic [PS-1:0]   if_parcel;
  logic [XLEN-1:0] if_parcel_pc;
  logic [PS/16-1:0] if_parcel_valid;
  logic            if_parcel_misaligned, if_parcel_page_fault;
  logic            mem_req, mem_ack = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
  logic [XLEN-1:0] mem_adr;
  logic [PS-1:0]   mem_rdata = '0;

  always #5 clk = ~clk;

  riscv_if_biu #(.XLEN(XLEN), .PARCEL_SIZE(PS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .if_nxt_pc(if_nxt_pc), .if_stall(if_stall),
    .if_flush(if_flush), .if_stall_nxt_pc(if_stall_nxt_pc), .if_parcel(if_parcel),
    .if_parcel_pc(if_parcel_pc), .if_parcel_valid(if_parcel_valid),
    .if_parcel_misaligned(if_parcel_misaligned), .if_parcel_page_fault(if_parcel_page_fault),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  typedef struct { logic [31:0] data; logic [31:0] pc; logic mis; logic pf; } exp_t;
  typedef struct { logic [31:0] pc; logic stall, flush, ack, req, snp; } vec_t;

  exp_t        sb[$];
  logic [31:0] pend[$];
  int          n_chk = 0, n_fail = 0, n_got = 0;
  logic        seen, acc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5a5a_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    seen = 1'b0;
    if (if_parcel_valid != '0) begin
      seen = 1'b1;
      n_got++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_parcel: got pc %0h data %0h, none expected",
                 if_parcel_pc, if_parcel);
      end else begin
        e = sb.pop_front();
        chk("parcel_valid", if_parcel_valid, 2'b11);
        chk("parcel_data", if_parcel, e.data);
        chk("parcel_pc", if_parcel_pc, e.pc);
        chk("parcel_misaligned", if_parcel_misaligned, e.mis);
        chk("parcel_page_fault", if_parcel_page_fault, e.pf);
      end
    end
  endtask

  // Observe at the falling edge; record requests the bus accepted.
  task automatic sample();
    @(negedge clk);
    check_out();
    acc = mem_req & mem_ack;
    if (acc) pend.push_back(if_nxt_pc);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
  endtask

  // Return the oldest outstanding request; keep=0 means the DUT must drop it.
  task automatic respond(input logic keep, input logic err);
    exp_t e;
    logic [31:0] a;
    a = pend.pop_front();
    mem_rvalid = 1'b1;
    mem_rdata  = mem_data(a);
    mem_err    = err;
    if (keep) begin
      e.data = mem_data(a); e.pc = a; e.mis = 1'b0; e.pf = err;
      sb.push_back(e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    exp_t e;
    logic [31:0] pc;
    int got0, acc_cnt;

    tbl[0] = '{32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{32'h200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{32'h200, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{32'h202, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{32'h201, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{32'h203, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{32'h3fc, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset with active-looking inputs
    if_nxt_pc = 32'h200; if_stall = 1'b0; mem_ack = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    repeat (2) @(posedge clk);
    #1;
    sample();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall_nxt_pc", if_stall_nxt_pc, 1);
    chk("rst_valid", if_parcel_valid, 0);
    chk("rst_parcel", if_parcel, 0);
    chk("rst_parcel_pc", if_parcel_pc, 0);
    chk("rst_misaligned", if_parcel_misaligned, 0);
    chk("rst_page_fault", if_parcel_page_fault, 0);
    adv();
    rstn = 1'b1; if_stall = 1'b1; mem_ack = 1'b0;

    // Issue-condition table from an idle pipe; inputs return to a safe
    // state before every edge so no state changes.
    for (int i = 0; i < 8; i++) begin
      if_nxt_pc = tbl[i].pc; if_stall = tbl[i].stall;
      if_flush = tbl[i].flush; mem_ack = tbl[i].ack;
      #1;
      chk($sformatf("tbl%0d_mem_req", i), mem_req, tbl[i].req);
      chk($sformatf("tbl%0d_stall_nxt_pc", i), if_stall_nxt_pc, tbl[i].snp);
      chk($sformatf("tbl%0d_mem_adr", i), mem_adr, tbl[i].pc);
      chk($sformatf("tbl%0d_valid", i), if_parcel_valid, 0);
      if_stall = 1'b1; if_flush = 1'b0; mem_ack = 1'b0;
      adv();
    end

    // Scenario 1: single fetch, parcel one cycle after rvalid
    if_stall = 1'b0; if_nxt_pc = 32'h200; mem_ack = 1'b1;
    sample();
    chk("s1_req", mem_req, 1); chk("s1_adr", mem_adr, 32'h200); chk("s1_snp", if_stall_nxt_pc, 0);
    adv();
    mem_ack = 1'b0; if_nxt_pc = 32'h204; respond(1'b1, 1'b0);
    sample();
    chk("s1_latency_valid", if_parcel_valid, 0);
    adv();
    sample(); chk("s1_seen", seen, 1);
    adv();

    // Scenario 2: fill DEPTH with no responses
    if_nxt_pc = 32'h200; mem_ack = 1'b1;
    sample(); chk("s2_req0", mem_req, 1); chk("s2_adr0", mem_adr, 32'h200);
    adv();
    if_nxt_pc = 32'h204;
    sample(); chk("s2_req1", mem_req, 1); chk("s2_adr1", mem_adr, 32'h204);
    adv();
    if_nxt_pc = 32'h208;
    sample(); chk("s2_full_req", mem_req, 0); chk("s2_full_snp", if_stall_nxt_pc, 1);
    adv();

    // Scenario 3: flush with two in flight, both responses stale
    if_flush = 1'b1;
    sample(); chk("s3_flush_req", mem_req, 0); chk("s3_flush_valid", if_parcel_valid, 0);
    adv();
    if_flush = 1'b0; if_nxt_pc = 32'h400; respond(1'b0, 1'b0);
    sample(); chk("s3_still_full", mem_req, 0);
    adv();
    respond(1'b0, 1'b0);
    sample(); chk("s3_req_while_discard", mem_req, 1); chk("s3_adr", mem_adr, 32'h400);
    adv();
    mem_ack = 1'b0; if_nxt_pc = 32'h404; respond(1'b1, 1'b0);
    sample(); chk("s3_stale_not_emitted", if_parcel_valid, 0);
    adv();
    sample(); chk("s3_seen", seen, 1);
    adv();

    // Scenario 4: misaligned PC on an idle pipe
    if_nxt_pc = 32'h202; mem_ack = 1'b1;
    e.data = 32'h13; e.pc = 32'h202; e.mis = 1'b1; e.pf = 1'b0; sb.push_back(e);
    sample(); chk("s4_req", mem_req, 0); chk("s4_snp", if_stall_nxt_pc, 0);
    adv();
    if_nxt_pc = 32'h204; mem_ack = 1'b0;
    sample(); chk("s4_seen", seen, 1);
    adv();

    // Scenario 5: bus error becomes page fault
    if_nxt_pc = 32'h300; mem_ack = 1'b1;
    sample(); chk("s5_req", mem_req, 1);
    adv();
    mem_ack = 1'b0; if_nxt_pc = 32'h304; respond(1'b1, 1'b1);
    sample(); adv();
    sample(); chk("s5_seen", seen, 1);
    adv();

    // Scenario 6: stall holds a queued parcel, then emitted once
    if_nxt_pc = 32'h500; mem_ack = 1'b1;
    sample(); adv();
    mem_ack = 1'b0; if_nxt_pc = 32'h504; respond(1'b1, 1'b0);
    sample(); adv();
    if_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk($sformatf("s6_stall%0d_valid", k), if_parcel_valid, 0);
      chk($sformatf("s6_stall%0d_data", k), if_parcel, mem_data(32'h500));
      chk($sformatf("s6_stall%0d_pc", k), if_parcel_pc, 32'h500);
      adv();
    end
    if_stall = 1'b0;
    sample(); chk("s6_seen", seen, 1);
    adv();
    sample(); chk("s6_once", if_parcel_valid, 0);
    adv();

    // Flush discards a parcel already queued
    if_nxt_pc = 32'h600; mem_ack = 1'b1;
    sample(); adv();
    mem_ack = 1'b0; if_stall = 1'b1; respond(1'b0, 1'b0);
    sample(); adv();
    if_flush = 1'b1;
    sample(); chk("s7_flush_valid", if_parcel_valid, 0);
    adv();
    if_flush = 1'b0; if_stall = 1'b0;
    sample(); chk("s7_after_valid", if_parcel_valid, 0); chk("s7_empty_parcel", if_parcel, 0);
    adv();

    // Unsolicited response must not underflow inflight
    if_stall = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hbad0_bad0;
    sample(); adv();
    if_stall = 1'b0; if_nxt_pc = 32'h700; mem_ack = 1'b1;
    sample(); chk("s8_req", mem_req, 1); chk("s8_valid", if_parcel_valid, 0);
    adv();
    mem_ack = 1'b0; if_nxt_pc = 32'h704; respond(1'b1, 1'b0);
    sample(); adv();
    sample(); chk("s8_seen", seen, 1);
    adv();

    // Flush coinciding with a response: only one stale response remains
    if_nxt_pc = 32'h800; mem_ack = 1'b1;
    sample(); adv();
    if_nxt_pc = 32'h804;
    sample(); adv();
    mem_ack = 1'b0; if_nxt_pc = 32'h808; if_flush = 1'b1; respond(1'b0, 1'b0);
    sample(); adv();
    if_flush = 1'b0; if_nxt_pc = 32'h900; mem_ack = 1'b1;
    sample(); chk("s9_req", mem_req, 1);
    adv();
    mem_ack = 1'b0; if_nxt_pc = 32'h904; respond(1'b0, 1'b0);
    sample(); adv();
    respond(1'b1, 1'b0);
    sample(); adv();
    sample(); chk("s9_seen", seen, 1);
    adv();

    // Randomized in-order stream with back-pressure
    got0 = n_got; acc_cnt = 0; pc = 32'h1000;
    for (int c = 0; c < 400; c++) begin
      if_nxt_pc = pc;
      if_stall  = ($urandom_range(0, 3) == 0);
      mem_ack   = ($urandom_range(0, 2) != 0);
      if (pend.size() > 0 && $urandom_range(0, 1) == 1)
        respond(1'b1, $urandom_range(0, 7) == 0);
      sample();
      if (acc) begin pc += 4; acc_cnt++; end
      adv();
    end
    if_stall = 1'b0; mem_ack = 1'b0;
    for (int k = 0; k < 16 && pend.size() > 0; k++) begin
      respond(1'b1, 1'b0);
      sample(); adv();
    end
    repeat (4) begin sample(); adv(); end
    chk("stream_pend_drained", pend.size(), 0);
    chk("stream_sb_drained", sb.size(), 0);
    chk("stream_count", n_got - got0, acc_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
